// File: rtl/mycpu_pkg.sv
// Shared decode constants for the MIPS core: opcodes, functs, next-PC selects, reset PC.
package mycpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [1:0] {
    JEN_SEQ = 2'b00,
    JEN_REL = 2'b01,
    JEN_ABS = 2'b10,
    JEN_REG = 2'b11
  } jen_e;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch/EXE-facing signal bundle of the decode stage; slave is the ID stage side.
interface inst_decode_stage_if;

  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        exe_allowin;
  logic        allowIN;
  logic [1:0]  jen;
  logic [31:0] offset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_link;

  modport slave (
    input  inst_sram_en, inst_sram_addr, inst_sram_rdata, rs_value, rt_value, exe_allowin,
    output allowIN, jen, offset, id_valid, id_pc, id_inst, id_link
  );

  modport master (
    output inst_sram_en, inst_sram_addr, inst_sram_rdata, rs_value, rt_value, exe_allowin,
    input  allowIN, jen, offset, id_valid, id_pc, id_inst, id_link
  );

endinterface

// File: rtl/id_branch_unit.sv
// Combinational branch/jump resolution for the ID head instruction (before fire gating).
// REGIMM branches (BLTZ/BGEZ/BLTZAL/BGEZAL) decode only when ID_REGIMM_BRANCH_EN is defined.
module id_branch_unit
  import mycpu_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  output logic [1:0]  jen,
  output logic [31:0] offset,
  output logic        link
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] j_target;
  logic        unused_pc;

  assign opcode    = inst[31:26];
  assign funct     = inst[5:0];
  assign pc_plus4  = id_pc + 32'd4;
  assign br_offset = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign unused_pc = ^pc_plus4[27:0];

`ifdef ID_REGIMM_BRANCH_EN
  logic [4:0] rt;
  assign rt = inst[20:16];
`endif

  always_comb begin
    jen    = JEN_SEQ;
    offset = '0;
    link   = 1'b0;
    case (opcode)
      OP_BEQ: if (rs_value == rt_value) begin
        jen    = JEN_REL;
        offset = br_offset;
      end
      OP_BNE: if (rs_value != rt_value) begin
        jen    = JEN_REL;
        offset = br_offset;
      end
      OP_BLEZ: if ($signed(rs_value) <= 0) begin
        jen    = JEN_REL;
        offset = br_offset;
      end
      OP_BGTZ: if ($signed(rs_value) > 0) begin
        jen    = JEN_REL;
        offset = br_offset;
      end
      OP_J: begin
        jen    = JEN_ABS;
        offset = j_target;
      end
      OP_JAL: begin
        jen    = JEN_ABS;
        offset = j_target;
        link   = 1'b1;
      end
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          jen    = JEN_REG;
          offset = rs_value;
          link   = (funct == FN_JALR);
        end
      end
`ifdef ID_REGIMM_BRANCH_EN
      OP_REGIMM: begin
        // Link forms write PC+8 even when the branch falls through.
        link = (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
        if (((rt == RT_BLTZ || rt == RT_BLTZAL) && rs_value[31]) ||
            ((rt == RT_BGEZ || rt == RT_BGEZAL) && !rs_value[31])) begin
          jen    = JEN_REL;
          offset = br_offset;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// MIPS ID stage: 2-entry holding buffer fed by the 1-cycle-latency instruction SRAM,
// valid/allowin handshake to EXE, branch resolution back to fetch. Optional: ID_REGIMM_BRANCH_EN.
module inst_decode_stage
  import mycpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input logic                  clk,
  input logic                  rst,
  inst_decode_stage_if.slave   bus
);

  if (DEPTH != 2) begin : g_depth_check
    $error("inst_decode_stage: only DEPTH == 2 is supported");
  end

  buf_state_e  state_q;
  logic        pend_q;
  logic [31:0] pend_pc_q;
  logic [31:0] head_pc_q, head_inst_q;
  logic [31:0] tail_pc_q, tail_inst_q;

  logic        fire;
  logic [2:0]  occ_next;
  logic [1:0]  br_jen;
  logic [31:0] br_offset;
  logic        br_link;

  assign bus.id_valid = (state_q != StEmpty);
  assign bus.id_pc    = head_pc_q;
  assign bus.id_inst  = head_inst_q;
  assign fire         = bus.id_valid && bus.exe_allowin;

  // Reserve a slot for every outstanding request so returning data is never dropped.
  assign occ_next    = {1'b0, state_q} + {2'b00, pend_q} - {2'b00, fire};
  assign bus.allowIN = (occ_next < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      head_pc_q   <= RESET_PC;
      head_inst_q <= '0;
      tail_pc_q   <= '0;
      tail_inst_q <= '0;
    end else begin
      pend_q    <= bus.inst_sram_en;
      pend_pc_q <= bus.inst_sram_addr;
      unique case (state_q)
        StEmpty: begin
          if (pend_q) begin
            head_pc_q   <= pend_pc_q;
            head_inst_q <= bus.inst_sram_rdata;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (pend_q && fire) begin
            head_pc_q   <= pend_pc_q;
            head_inst_q <= bus.inst_sram_rdata;
          end else if (pend_q) begin
            tail_pc_q   <= pend_pc_q;
            tail_inst_q <= bus.inst_sram_rdata;
            state_q     <= StFull;
          end else if (fire) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (fire) begin
            head_pc_q   <= tail_pc_q;
            head_inst_q <= tail_inst_q;
            if (pend_q) begin
              tail_pc_q   <= pend_pc_q;
              tail_inst_q <= bus.inst_sram_rdata;
            end else begin
              state_q <= StOne;
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  id_branch_unit u_branch (
    .inst     (head_inst_q),
    .id_pc    (head_pc_q),
    .rs_value (bus.rs_value),
    .rt_value (bus.rt_value),
    .jen      (br_jen),
    .offset   (br_offset),
    .link     (br_link)
  );

  // Redirect only in the cycle the control instruction leaves for EXE.
  assign bus.jen     = fire ? br_jen : JEN_SEQ;
  assign bus.offset  = (fire && (br_jen != JEN_SEQ)) ? br_offset : 32'd0;
  assign bus.id_link = bus.id_valid && br_link;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed self-checking bench for inst_decode_stage (REGIMM step adapts to ID_REGIMM_BRANCH_EN).
module tb_inst_decode_stage;
  import mycpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_decode_stage_if bus ();

  inst_decode_stage #(
    .RESET_PC (32'hbfc00000),
    .DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Bring one instruction into an empty buffer without retiring it.
  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    bus.exe_allowin    = 1'b0;
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = pc;
    step();
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_rdata = inst;
    step();
  endtask

  task automatic fire_check(input string tag, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [1:0] exp_jen, input logic [31:0] exp_off);
    bus.rs_value    = rs;
    bus.rt_value    = rt;
    bus.exe_allowin = 1'b1;
    settle();
    chk({tag, "_jen"}, {30'd0, bus.jen}, {30'd0, exp_jen});
    chk({tag, "_off"}, bus.offset, exp_off);
    step();
    bus.exe_allowin = 1'b0;
    settle();
    chk({tag, "_jen_after"}, {30'd0, bus.jen}, 32'd0);
  endtask

  // A buffer write while FULL must always coincide with a head retire.
  always @(negedge clk) begin
    if (!rst && dut.pend_q && dut.state_q == StFull) begin
      n_cmp++;
      assert (bus.exe_allowin === 1'b1) else begin
        n_err++;
        $error("FAIL overflow: observed exe_allowin %b expected 1", bus.exe_allowin);
      end
    end
  end

  logic [1:0] exp_rjen;
  logic       exp_rlink;

  initial begin
    rst                 = 1'b1;
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_addr  = '0;
    bus.inst_sram_rdata = '0;
    bus.rs_value        = '0;
    bus.rt_value        = '0;
    bus.exe_allowin     = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_pc", bus.id_pc, 32'hbfc00000);
    chk("rst_inst", bus.id_inst, 32'd0);
    chk("rst_jen", {30'd0, bus.jen}, 32'd0);
    chk("rst_off", bus.offset, 32'd0);
    chk("rst_link", {31'd0, bus.id_link}, 32'd0);
    chk("rst_allowin", {31'd0, bus.allowIN}, 32'd1);
    rst = 1'b0;

    // First fetch: NOP at the reset vector.
    bus.exe_allowin    = 1'b1;
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'hbfc00000;
    step();
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_rdata = 32'h0;
    settle();
    chk("t1_allowin_pend", {31'd0, bus.allowIN}, 32'd1);
    step();
    chk("t1_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("t1_pc", bus.id_pc, 32'hbfc00000);
    chk("t1_jen", {30'd0, bus.jen}, 32'd0);
    step();
    chk("t1_drain", {31'd0, bus.id_valid}, 32'd0);

    // BEQ imm=3: held (no fire) gives no redirect; taken when rs==rt.
    load(32'hbfc00004, 32'h10220003);
    chk("beq_hold_jen", {30'd0, bus.jen}, 32'd0);
    chk("beq_link", {31'd0, bus.id_link}, 32'd0);
    fire_check("beq_taken", 32'd5, 32'd5, 2'b01, 32'h0000000c);
    load(32'hbfc00004, 32'h10220003);
    fire_check("beq_nt", 32'd4, 32'd5, 2'b00, 32'h0);

    load(32'hbfc00008, 32'h1422ffff);
    fire_check("bne_neg", 32'd1, 32'd2, 2'b01, 32'hfffffffc);
    load(32'hbfc0000c, 32'h1c200010);
    fire_check("bgtz_nt", 32'hffffffff, 32'd0, 2'b00, 32'h0);
    load(32'hbfc0000c, 32'h18200010);
    fire_check("blez_zero", 32'd0, 32'd7, 2'b01, 32'h00000040);

    load(32'hbfc00010, 32'h08100000);
    fire_check("j", 32'd0, 32'd0, 2'b10, 32'hb0400000);

    // JAL at the top of the address space: PC+4 wraps to 0.
    load(32'hfffffffc, 32'h0c000005);
    chk("jal_link", {31'd0, bus.id_link}, 32'd1);
    fire_check("jal_wrap", 32'd0, 32'd0, 2'b10, 32'h00000014);

    load(32'hbfc00018, 32'h00200008);
    chk("jr_link", {31'd0, bus.id_link}, 32'd0);
    fire_check("jr", 32'h80001234, 32'd0, 2'b11, 32'h80001234);
    load(32'hbfc0001c, 32'h0020f809);
    chk("jalr_link", {31'd0, bus.id_link}, 32'd1);
    fire_check("jalr", 32'h00400000, 32'd0, 2'b11, 32'h00400000);

    // Back-pressure: fill both slots, then release and check ordering.
    bus.exe_allowin    = 1'b0;
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h00001000;
    step();
    bus.inst_sram_addr  = 32'h00001004;
    bus.inst_sram_rdata = 32'h00851021;
    settle();
    chk("bp_allow0", {31'd0, bus.allowIN}, 32'd1);
    step();
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_rdata = 32'h3c01abcd;
    settle();
    chk("bp_allow1", {31'd0, bus.allowIN}, 32'd0);
    chk("bp_head0", bus.id_pc, 32'h00001000);
    step();
    chk("bp_allow_full", {31'd0, bus.allowIN}, 32'd0);
    chk("bp_valid_full", {31'd0, bus.id_valid}, 32'd1);
    bus.exe_allowin     = 1'b1;
    bus.inst_sram_en    = 1'b1;
    bus.inst_sram_addr  = 32'h00001008;
    bus.inst_sram_rdata = 32'h0;
    settle();
    chk("bp_allow_rel", {31'd0, bus.allowIN}, 32'd1);
    chk("bp_e0_pc", bus.id_pc, 32'h00001000);
    chk("bp_e0_inst", bus.id_inst, 32'h00851021);
    step();
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_rdata = 32'h24420001;
    settle();
    chk("bp_e1_pc", bus.id_pc, 32'h00001004);
    chk("bp_e1_inst", bus.id_inst, 32'h3c01abcd);
    chk("bp_allow_e1", {31'd0, bus.allowIN}, 32'd1);
    step();
    chk("bp_e2_pc", bus.id_pc, 32'h00001008);
    chk("bp_e2_inst", bus.id_inst, 32'h24420001);
    step();
    chk("bp_drain", {31'd0, bus.id_valid}, 32'd0);
    bus.exe_allowin = 1'b0;

    // Reset right after a request: returning data must be discarded.
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h00002000;
    step();
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_rdata = 32'h11111111;
    rst                 = 1'b1;
    step();
    rst                 = 1'b0;
    bus.inst_sram_rdata = 32'h22222222;
    settle();
    chk("rstmid_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rstmid_allow", {31'd0, bus.allowIN}, 32'd1);
    step();
    chk("rstmid_valid2", {31'd0, bus.id_valid}, 32'd0);
    chk("rstmid_pc", bus.id_pc, 32'hbfc00000);

    // BLTZAL with a negative rs.
`ifdef ID_REGIMM_BRANCH_EN
    exp_rjen  = 2'b01;
    exp_rlink = 1'b1;
`else
    exp_rjen  = 2'b00;
    exp_rlink = 1'b0;
`endif
    load(32'hbfc00020, 32'h04300002);
    chk("bltzal_link", {31'd0, bus.id_link}, {31'd0, exp_rlink});
    fire_check("bltzal", 32'hffffffff, 32'd0, exp_rjen,
               (exp_rjen == 2'b01) ? 32'h00000008 : 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
